fb_scanout: RTL
===============

FB_SCANOUT -- requirements
Module: fb_scanout

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, 100 MHz system clock
- rst, in, 1, asynchronous reset, active-high
- src_addr, out, 19, framebuffer read address, row-major y*H_ACTIVE+x
- src_rd, out, 1, framebuffer read strobe, one clk per active pixel
- src_data, in, 16, RGB565 pixel, valid exactly 1 clk after src_rd
- hs, out, 1, horizontal sync, active-low
- vs, out, 1, vertical sync, active-low
- r, out, 4, red
- g, out, 4, green
- b, out, 4, blue
- frame_start, out, 1, one-clk pulse at the start of each frame
REQ-003 Single clock domain. Reset is asynchronous and active-high.

Function
REQ-004 2-bit phase counter wraps 0..3 every clk; one pixel slot = 4 clks (25 MHz pixel rate).
REQ-005 h_cnt counts 0..H_TOTAL-1 (H_TOTAL = sum of H params = 800) and advances when phase==3; wraps to 0.
REQ-006 v_cnt counts 0..V_TOTAL-1 (525) and advances when h_cnt wraps; wraps to 0.
REQ-007 Active region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-008 src_rd = 1 only at phase 0 of an active slot; src_rd = 0 at all other times.
REQ-009 src_addr = v_cnt*H_ACTIVE+h_cnt, maintained by a running address counter (no multiplier):
- +1 per active read
- reset to 0 when v_cnt wraps
- range 0..307199
REQ-010 src_data is captured at phase 1 of the same slot into a pixel register.
REQ-011 Color mapping: r=d[15:12], g=d[10:7], b=d[4:1].
REQ-012 r, g, b, hs, vs are registered and update together only at phase 3 and hold for 4 clks.
REQ-013 In non-active slots, r/g/b = 0.
REQ-014 hs = 0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, evaluated for the slot being output.
REQ-015 vs = 0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, evaluated for the slot being output.
REQ-016 Output alignment: the values output at phase 3 of slot (h,v) reflect slot (h,v) itself; pipeline latency from src_rd to RGB = 3 clks.
REQ-017 frame_start = 1 for exactly one clk, at phase 0 of slot (0,0), coincident with the first src_rd of the frame.
REQ-018 src_data is ignored in every clk other than phase 1 of an active slot.
REQ-019 Derived widths: h_cnt 10 bits, v_cnt 10 bits, address counter 19 bits; all counters wrap with no overflow beyond their terminal value.

Reset
REQ-020 While rst=1, all of the following hold: phase, h_cnt, v_cnt, and address counter = 0; src_rd=0; frame_start=0; r/g/b=0; hs=1; vs=1.
REQ-021 Reset asserted mid-frame aborts immediately; no further src_rd is issued until rst is released.
REQ-022 First clk after rst deassertion is phase 0 of slot (0,0): src_rd=1, src_addr=0, frame_start=1.

Verification
REQ-023 Release rst -> src_rd at clk 0, 4, 8, ... with src_addr 0, 1, 2, ...; frame_start=1 only at clk 0.
REQ-024 Memory model returns src_data=16'hF81F for every address -> r=F, g=0, b=F from clk 3 through the last active slot; r/g/b=0 from h_cnt 640 onward.
REQ-025 Count one full line -> 640 src_rd pulses; hs low for 96 slots (384 clks) starting at slot 656; line period 3200 clks.
REQ-026 Count one full frame -> 307200 src_rd pulses; last src_addr=307199; vs low for lines 490-491; next frame_start exactly 1,680,000 clks after the first.
REQ-027 Assert rst at v_cnt=100, h_cnt=300, phase 2; release after 7 clks -> outputs at reset values during rst; restart at src_addr 0 with frame_start.
REQ-028 Memory model drives src_data = address-low-16 bits, with junk on non-phase-1 clks -> output colors match the address pattern only; junk never appears on r/g/b.

Source files
------------

// File: rtl/fb_scanout.sv
// Framebuffer scan-out engine: walks a raster at one pixel per 4 clks, fetches
// RGB565 pixels from a synchronous framebuffer and emits registered RGB444 with syncs.
module fb_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  output logic [18:0] src_addr,
  output logic        src_rd,
  input  logic [15:0] src_data,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [1:0]  phase;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [18:0] addr_cnt;
  logic [15:0] pix_q;
  logic        active;
  logic        rd_slot;
  logic        last_px;

  // NOTE: combinational decode uses blocking '=' with a default first, so no
  // path through the block can leave a variable unassigned and infer a latch.
  always_comb begin
    active  = 1'b0;
    rd_slot = 1'b0;
    last_px = 1'b0;
    active  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    rd_slot = active && (phase == 2'd0);
    last_px = (h_cnt == H_ACT - 10'd1) && (v_cnt == V_ACT - 10'd1);
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples the
  // pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= 2'd0;
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end else begin
      phase <= phase + 2'd1;
      if (phase == 2'd3) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= 10'd0;
          v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  // Running row-major address; folds back to 0 after the last visible pixel
  // so it is already 0 when the next frame starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_cnt <= 19'd0;
    end else if (rd_slot) begin
      addr_cnt <= last_px ? 19'd0 : addr_cnt + 19'd1;
    end
  end

  // NOTE: the pixel register is pure datapath; it is only ever consumed when
  // the slot is active (after a fresh capture), so it carries no reset.
  always_ff @(posedge clk) begin
    if (phase == 2'd1 && active) begin
      pix_q <= src_data;
    end
  end

  // Outputs load on the last clk of a slot, so they become visible at phase 3
  // and hold through phases 0-2 of the following slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r  <= 4'd0;
      g  <= 4'd0;
      b  <= 4'd0;
      hs <= 1'b1;
      vs <= 1'b1;
    end else if (phase == 2'd2) begin
      r  <= active ? pix_q[15:12] : 4'd0;
      g  <= active ? pix_q[10:7]  : 4'd0;
      b  <= active ? pix_q[4:1]   : 4'd0;
      hs <= !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
      vs <= !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    end
  end

  // Strobes are gated by rst so they are quiet during reset and fire in the
  // very first clk after release.
  assign src_addr    = addr_cnt;
  assign src_rd      = rd_slot && !rst;
  assign frame_start = !rst && (phase == 2'd0) && (h_cnt == 10'd0) && (v_cnt == 10'd0);

endmodule
